dec138_scan_seq: RTL and testbench
==================================

DEC138_SCAN_SEQ -- requirements
Module: dec138_scan_seq

Interface
REQ-001 SHALL provide parameter DIV, default 4, giving clock cycles per scan step in RUN; legal range 1..65535.
REQ-002 SHALL provide port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port EN  input  1  1 = free-running scan, 0 = hold/manual step.
REQ-005 SHALL provide port DIR  input  1  0 = count up, 1 = count down.
REQ-006 SHALL provide port STEP  input  1  manual advance request; rising edge only.
REQ-007 SHALL provide port LEN  input  3  last scan index; scan range 0..LEN.
REQ-008 SHALL provide ports G1, G2A, G2B  output  1 each  enables driving the downstream 3-to-8 decoder.
REQ-009 SHALL provide ports C, B, A  output  1 each  decoder select, {C,B,A} = current index.
REQ-010 SHALL provide port WRAP  output  1  one-cycle pulse on a wrapping advance.

Function
REQ-011 SHALL implement states IDLE, RUN, HOLD and BLANK; BLANK exists only per REQ-030.
REQ-012 In IDLE and BLANK, outputs SHALL be G1=0, G2A=1, G2B=1, so all decoder outputs are high.
REQ-013 In RUN and HOLD, outputs SHALL be G1=1, G2A=0, G2B=0; {C,B,A} SHALL always equal the registered index.
REQ-014 Transitions out of IDLE SHALL be: EN=1 -> RUN; otherwise a STEP rising edge -> HOLD with no advance.
REQ-015 Transitions between RUN and HOLD SHALL be: RUN with EN=0 -> HOLD, no advance that cycle; HOLD with EN=1 -> RUN.
REQ-016 In RUN, a 16-bit prescaler SHALL count 0..DIV-1; when count==DIV-1, the block advances and the prescaler clears.
REQ-017 The prescaler SHALL be held at 0 in IDLE, HOLD and BLANK, and cleared on entering RUN.
REQ-018 STEP SHALL be edge-detected against a registered copy; a level held high SHALL produce exactly one advance.
REQ-019 A STEP edge SHALL advance only in HOLD; it SHALL be ignored in RUN and BLANK.
REQ-020 In HOLD, if EN=1 and a STEP edge occur in the same cycle, EN SHALL win: the next state is RUN and no step is taken.
REQ-021 Up next index: idx>=LEN -> 0, else idx+1.
REQ-022 Down next index: idx==0 or idx>LEN -> LEN, else idx-1.
REQ-023 WRAP SHALL be 1 for exactly the cycle in which the new index first appears, whenever that advance was not a plain +/-1 step.
REQ-024 Advance latency: index and WRAP update one cycle after the tick or STEP-edge cycle.
REQ-025 DIR and LEN SHALL be sampled at the advance cycle; changes between advances SHALL have no other effect.
REQ-026 Reducing LEN below the current index SHALL NOT move the index until the next advance, which then follows REQ-021/REQ-022.

Reset
REQ-027 When RST=1 at a clock edge, the block SHALL enter IDLE with index 0, prescaler 0, STEP-history 0 and WRAP=0, so G1=0, G2A=1, G2B=1, C=B=A=0.
REQ-028 RST SHALL override all other inputs, including mid-RUN and during BLANK.
REQ-029 After RST falls, the first transition SHALL follow REQ-014.

Configuration
REQ-030 With macro SCAN_BLANK_EN defined, every advance SHALL go through BLANK for one cycle, then enter RUN if EN=1, else HOLD.
REQ-031 Under REQ-030, BLANK SHALL show the new index on C/B/A and WRAP; the decoder SHALL be disabled for that cycle (break-before-make).
REQ-032 Under REQ-030, the RUN step period SHALL be DIV+1 cycles.
REQ-033 Without SCAN_BLANK_EN, no BLANK state SHALL exist; the new index SHALL drive directly with enables held active, and the RUN period SHALL be DIV cycles.

Verification
REQ-034 DIV=4, LEN=7, DIR=0, EN=1 after reset -> {C,B,A} = 0,1,...,7,0 with each value held 4 cycles; WRAP=1 for the single cycle of 7->0; G1=1 throughout RUN.
REQ-035 DIR=1, LEN=5, EN=1 starting from idx 0 -> next index 5 with WRAP=1, then 4 and 3 with WRAP=0.
REQ-036 Drop EN at idx 3 -> HOLD with idx 3; raise STEP and hold it 5 cycles -> exactly one advance to 4; a second pulse -> 5.
REQ-037 LEN changed 7->2 while idx=5, DIR=0 -> next advance gives idx 0 with WRAP=1; the following advances give 1, 2, 0.
REQ-038 With SCAN_BLANK_EN and DIV=4 -> at each advance, one cycle of G1=0, G2A=G2B=1 with the new {C,B,A}; the step period measures 5 cycles.
REQ-039 RST=1 for one cycle mid-RUN at idx 6 with EN held 1 -> the next cycle shows IDLE outputs with idx 0; the cycle after shows RUN with G1=1 and idx 0.

Source files
------------

// File: rtl/dec138_scan_seq.sv
// Scan sequencer for a 3-to-8 decoder: free-running or manual stepping over 0..LEN.
// Define SCAN_BLANK_EN to insert a one-cycle decoder-disabled BLANK state on every advance.
module dec138_scan_seq #(
  parameter int DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       DIR,
  input  logic       STEP,
  input  logic [2:0] LEN,
  output logic       G1,
  output logic       G2A,
  output logic       G2B,
  output logic       C,
  output logic       B,
  output logic       A,
  output logic       WRAP
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, RUN, HOLD, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
`endif

  localparam logic [15:0] PTOP = 16'(DIV - 1);

  state_t      state, state_nx;
  logic [2:0]  idx, idx_nx, adv_idx;
  logic [15:0] presc, presc_nx;
  logic        step_q, step_edge, adv, adv_wrap, wrap_q, wrap_nx;

  assign step_edge = STEP & ~step_q;

  // DIR/LEN only matter here, and this result is only used on an advance
  always_comb begin
    if (DIR) adv_idx = (idx == 3'd0 || idx > LEN) ? LEN : idx - 3'd1;
    else     adv_idx = (idx >= LEN) ? 3'd0 : idx + 3'd1;
    if (DIR) adv_wrap = ({1'b0, adv_idx} + 4'd1) != {1'b0, idx};
    else     adv_wrap = ({1'b0, idx} + 4'd1) != {1'b0, adv_idx};
  end

  always_comb begin
    state_nx = state;
    presc_nx = 16'd0;
    adv      = 1'b0;
    unique case (state)
      IDLE:    if (EN) state_nx = RUN;
               else if (step_edge) state_nx = HOLD;
      RUN:     if (!EN) state_nx = HOLD;
               else if (presc == PTOP) adv = 1'b1;
               else presc_nx = presc + 16'd1;
      HOLD:    if (EN) state_nx = RUN;
               else if (step_edge) adv = 1'b1;
`ifdef SCAN_BLANK_EN
      BLANK:   state_nx = EN ? RUN : HOLD;
`endif
      default: state_nx = IDLE;
    endcase
`ifdef SCAN_BLANK_EN
    if (adv) state_nx = BLANK;
`endif
    idx_nx  = adv ? adv_idx : idx;
    wrap_nx = adv & adv_wrap;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      idx    <= 3'd0;
      presc  <= 16'd0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      presc  <= presc_nx;
      step_q <= STEP;
      wrap_q <= wrap_nx;
    end
  end

  assign G1          = (state == RUN) || (state == HOLD);
  assign G2A         = ~G1;
  assign G2B         = ~G1;
  assign {C, B, A}   = idx;
  assign WRAP        = wrap_q;

endmodule

// File: tb/tb_dec138_scan_seq.sv
// Bench for dec138_scan_seq: directed scenarios then random traffic, every cycle
// compared against a behavioural scan model (follows SCAN_BLANK_EN if defined).
module tb_dec138_scan_seq;
  localparam int DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_BLANK = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1, EN = 1'b0, DIR = 1'b0, STEP = 1'b0;
  logic [2:0] LEN = 3'd7;
  logic G1, G2A, G2B, C, B, A, WRAP;

  dec138_scan_seq #(.DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .STEP(STEP), .LEN(LEN),
    .G1(G1), .G2A(G2A), .G2B(G2B), .C(C), .B(B), .A(A), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int m_mode = M_IDLE, m_idx = 0, m_cnt = 0;
  bit m_stepq = 0, m_wrap = 0;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  function automatic logic [6:0] obs_vec();
    return {G1, G2A, G2B, C, B, A, WRAP};
  endfunction

  function automatic logic [6:0] exp_vec();
    bit on = (m_mode == M_RUN) || (m_mode == M_HOLD);
    logic [2:0] i = 3'(m_idx);
    return {on, !on, !on, i, m_wrap};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b (G1 G2A G2B C B A WRAP)", tag, obs, exp);
    end
  endtask

  // Reference: scan position moves by the spec's next-index rules once per tick
  // (every DIV cycles spent enabled) or per fresh STEP press while held.
  function automatic void model_clk(input bit rst, input bit en, input bit dir,
                                    input bit step, input int len);
    bit press = step && !m_stepq;
    bit advance = 0;
    int nidx;
    m_stepq = step;
    m_wrap  = 0;
    if (rst) begin
      m_mode = M_IDLE; m_idx = 0; m_cnt = 0; m_stepq = 0;
      return;
    end
    case (m_mode)
      M_IDLE:  begin
        if (en) m_mode = M_RUN; else if (press) m_mode = M_HOLD;
        m_cnt = 0;
      end
      M_RUN:   begin
        if (!en) begin m_mode = M_HOLD; m_cnt = 0; end
        else begin
          m_cnt++;
          if (m_cnt == DIV) begin advance = 1; m_cnt = 0; end
        end
      end
      M_HOLD:  begin
        if (en) m_mode = M_RUN; else if (press) advance = 1;
        m_cnt = 0;
      end
      default: begin
        m_mode = en ? M_RUN : M_HOLD;
        m_cnt = 0;
      end
    endcase
    if (advance) begin
      if (!dir) nidx = (m_idx >= len) ? 0 : m_idx + 1;
      else      nidx = (m_idx == 0 || m_idx > len) ? len : m_idx - 1;
      m_wrap = dir ? (nidx != m_idx - 1) : (nidx != m_idx + 1);
      m_idx  = nidx;
      if (BLANK_ON) m_mode = M_BLANK;
    end
  endfunction

  task automatic cyc(input bit rst, input bit en, input bit dir, input bit step,
                     input int len, input string tag);
    @(negedge CLK);
    RST = rst; EN = en; DIR = dir; STEP = step; LEN = 3'(len);
    @(posedge CLK);
    model_clk(rst, en, dir, step, len);
    #1;
    check(tag, obs_vec(), exp_vec());
  endtask

  initial begin
    bit r_en, r_dir, r_step;
    int r_len;

    // reset state
    cyc(1, 0, 0, 0, 7, "rst");
    cyc(1, 1, 0, 1, 7, "rst_override");
    check("rst_const", obs_vec(), 7'b0110_000);

    // free-running up scan over 0..7 with a wrap
    for (int k = 0; k < 1 + 9 * (DIV + 1); k++) cyc(0, 1, 0, 0, 7, "up_scan");

    // down scan LEN=5 from idx 0: 5 (wrap), 4, 3
    cyc(1, 0, 0, 0, 5, "rst2");
    for (int k = 0; k < 4 * (DIV + 1); k++) cyc(0, 1, 1, 0, 5, "down_scan");

    // manual stepping from idx 3
    cyc(1, 0, 0, 0, 7, "rst3");
    for (int k = 0; k < 200 && !(m_idx == 3 && m_mode == M_RUN); k++)
      cyc(0, 1, 0, 0, 7, "to_idx3");
    cyc(0, 0, 0, 0, 7, "en_drop");
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 7, "step_held");
    for (int k = 0; k < 2; k++) cyc(0, 0, 0, 0, 7, "step_low");
    cyc(0, 0, 0, 1, 7, "step2");
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 7, "step2_low");
    check("hold_idx5", obs_vec(), 7'b1001_010);

    // EN and STEP edge together in HOLD: EN wins
    cyc(0, 1, 0, 1, 7, "en_vs_step");
    cyc(0, 1, 0, 0, 7, "en_vs_step2");

    // LEN shrink below idx
    cyc(1, 0, 0, 0, 7, "rst4");
    for (int k = 0; k < 200 && !(m_idx == 5 && m_mode == M_RUN); k++)
      cyc(0, 1, 0, 0, 7, "to_idx5");
    for (int k = 0; k < 5 * (DIV + 1); k++) cyc(0, 1, 0, 0, 2, "len_shrink");

    // reset mid-run at idx 6, EN held
    for (int k = 0; k < 200 && !(m_idx == 6 && m_mode == M_RUN); k++)
      cyc(0, 1, 0, 0, 7, "to_idx6");
    cyc(1, 1, 0, 0, 7, "rst_midrun");
    check("rst_midrun_idle", obs_vec(), 7'b0110_000);
    cyc(0, 1, 0, 0, 7, "after_rst");
    check("after_rst_run", obs_vec(), 7'b1000_000);

    // random traffic
    r_en = 1; r_dir = 0; r_len = 7;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) r_en = !r_en;
      if ($urandom_range(0, 20) == 0) r_dir = $urandom_range(0, 1);
      if ($urandom_range(0, 25) == 0) r_len = $urandom_range(0, 7);
      r_step = ($urandom_range(0, 2) == 0);
      cyc($urandom_range(0, 199) == 0, r_en, r_dir, r_step, r_len, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
